// File: rtl/smi_self_link_flit_serializer_pkg.sv
// Shared SMI link definitions: default flit geometry and the SELF handshake helper
// used by both ends of a self-link.
package smi_self_link_flit_serializer_pkg;

  localparam int SMI_FLIT_WIDTH     = 16;
  localparam int SMI_FLITS_PER_WORD = 4;

  // Length field covers 0..FlitsPerWord-1 (flit count minus one).
  function automatic int smi_len_width(input int flits_per_word);
    return $clog2(flits_per_word);
  endfunction

  // A SELF transfer happens on any cycle where valid is high and stop is low.
  function automatic logic self_fire(input logic valid, input logic stop);
    return valid & ~stop;
  endfunction

endpackage

// File: rtl/smi_self_link_flit_serializer.sv
// SELF-link transmitter: splits wide frame words into narrow flits, LSB flit first,
// through a staging register (ST) feeding a shift register (SR).
module smi_self_link_flit_serializer
  import smi_self_link_flit_serializer_pkg::*;
#(
  parameter int FlitWidth    = SMI_FLIT_WIDTH,
  parameter int FlitsPerWord = SMI_FLITS_PER_WORD,
  parameter int LenWidth     = smi_len_width(FlitsPerWord)
) (
  input  logic                              clk,
  input  logic                              srst,
  input  logic                              wordInValid,
  input  logic [FlitWidth*FlitsPerWord-1:0] wordInData,
  input  logic [LenWidth-1:0]               wordInLen,
  input  logic                              wordInEof,
  output logic                              wordInStop,
  output logic                              flitOutValid,
  output logic [FlitWidth-1:0]              flitOutData,
  output logic                              flitOutEof,
  input  logic                              flitOutStop
);

  localparam int WordWidth = FlitWidth * FlitsPerWord;
  localparam int CntWidth  = LenWidth + 1;
  localparam logic [CntWidth-1:0] CntZero = '0;
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  logic [WordWidth-1:0] st_data_q, st_data_d;
  logic [LenWidth-1:0]  st_len_q,  st_len_d;
  logic                 st_eof_q,  st_eof_d;
  logic                 st_full_q, st_full_d;

  logic [WordWidth-1:0] sr_data_q, sr_data_d;
  logic                 sr_eof_q,  sr_eof_d;
  logic [CntWidth-1:0]  sr_cnt_q,  sr_cnt_d;

  // Upstream stop is its own flop: high through reset and the first cycle after it,
  // then it simply tracks whether ST is occupied.
  logic stop_q, stop_d;

  logic pop;
  logic accept;
  logic sr_reload;

  assign flitOutValid = (sr_cnt_q != CntZero);
  assign flitOutData  = sr_data_q[FlitWidth-1:0];
  assign flitOutEof   = sr_eof_q && (sr_cnt_q == CntOne);
  assign wordInStop   = stop_q;

  assign pop       = self_fire(flitOutValid, flitOutStop);
  assign accept    = self_fire(wordInValid, stop_q);
  assign sr_reload = (sr_cnt_q == CntZero) || ((sr_cnt_q == CntOne) && pop);

  always_comb begin
    // NOTE: every _d gets a hold value first so no path through this block can infer a latch.
    st_data_d = st_data_q;
    st_len_d  = st_len_q;
    st_eof_d  = st_eof_q;
    st_full_d = st_full_q;
    sr_data_d = sr_data_q;
    sr_eof_d  = sr_eof_q;
    sr_cnt_d  = sr_cnt_q;

    if (pop) begin
      sr_data_d = sr_data_q >> FlitWidth;
      sr_cnt_d  = sr_cnt_q - CntOne;
    end

    // ST always drains ahead of a new word; accept cannot coincide with a full ST.
    if (sr_reload) begin
      if (st_full_q) begin
        sr_data_d = st_data_q;
        sr_eof_d  = st_eof_q;
        sr_cnt_d  = {1'b0, st_len_q} + CntOne;
        st_full_d = 1'b0;
      end else if (accept) begin
        sr_data_d = wordInData;
        sr_eof_d  = wordInEof;
        sr_cnt_d  = {1'b0, wordInLen} + CntOne;
      end else begin
        sr_cnt_d  = CntZero;
      end
    end

    if (accept && !sr_reload) begin
      st_data_d = wordInData;
      st_len_d  = wordInLen;
      st_eof_d  = wordInEof;
      st_full_d = 1'b1;
    end

    stop_d = st_full_d;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sr_cnt_q  <= CntZero;
      st_full_q <= 1'b0;
      stop_q    <= 1'b1;
    end else begin
      sr_cnt_q  <= sr_cnt_d;
      st_full_q <= st_full_d;
      stop_q    <= stop_d;
    end
  end

  // NOTE: payload registers carry no reset; the count and full flags alone decide
  // whether their contents are ever observed.
  always_ff @(posedge clk) begin
    st_data_q <= st_data_d;
    st_len_q  <= st_len_d;
    st_eof_q  <= st_eof_d;
    sr_data_q <= sr_data_d;
    sr_eof_q  <= sr_eof_d;
  end

endmodule

// File: tb/tb_smi_self_link_flit_serializer.sv
// Self-checking bench for the SELF flit serializer: expected flits are queued when a
// word is accepted and compared as each flit leaves the DUT.
module tb_smi_self_link_flit_serializer;

  logic        clk;
  logic        srst;
  logic        wordInValid;
  logic [63:0] wordInData;
  logic [1:0]  wordInLen;
  logic        wordInEof;
  logic        wordInStop;
  logic        flitOutValid;
  logic [15:0] flitOutData;
  logic        flitOutEof;
  logic        flitOutStop;

  int tests_run    = 0;
  int tests_failed = 0;
  int gap_cnt      = 0;
  logic last_accept = 1'b0;

  // Scoreboard entries are {eof, data}.
  logic [16:0] sb_q[$];

  smi_self_link_flit_serializer #(
    .FlitWidth   (16),
    .FlitsPerWord(4),
    .LenWidth    (2)
  ) dut (
    .clk         (clk),
    .srst        (srst),
    .wordInValid (wordInValid),
    .wordInData  (wordInData),
    .wordInLen   (wordInLen),
    .wordInEof   (wordInEof),
    .wordInStop  (wordInStop),
    .flitOutValid(flitOutValid),
    .flitOutData (flitOutData),
    .flitOutEof  (flitOutEof),
    .flitOutStop (flitOutStop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic cycle();
    logic [16:0] exp;
    @(negedge clk);
    last_accept = 1'b0;
    if (srst) begin
      sb_q.delete();
    end else begin
      if (flitOutValid !== 1'b1 && sb_q.size() != 0) gap_cnt++;
      if (flitOutValid === 1'b1 && flitOutStop == 1'b0) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL flit_unexpected: got data=%h eof=%b, required no flit", flitOutData, flitOutEof);
        end else begin
          exp = sb_q.pop_front();
          if ({flitOutEof, flitOutData} !== exp) begin
            tests_failed++;
            $display("FAIL flit_compare: got data=%h eof=%b, required data=%h eof=%b",
                     flitOutData, flitOutEof, exp[15:0], exp[16]);
          end
        end
      end
      if (wordInValid && wordInStop === 1'b0) begin
        last_accept = 1'b1;
        for (int i = 0; i <= int'(wordInLen); i++)
          sb_q.push_back({wordInEof && (i == int'(wordInLen)), wordInData[i*16 +: 16]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] data, input logic [1:0] len, input logic eof);
    bit done = 0;
    wordInValid = 1'b1;
    wordInData  = data;
    wordInLen   = len;
    wordInEof   = eof;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = last_accept;
    end
    wordInValid = 1'b0;
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL send_timeout: word %h got accepted=0, required accepted=1 within 20 cycles", data);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) cycle();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: got %0d flits outstanding, required 0", name, sb_q.size());
    end
    tests_run++;
    if (flitOutValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle: got flitOutValid=%b, required 0", name, flitOutValid);
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (flitOutValid !== 1'b0 || wordInStop !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_hold: got valid=%b stop=%b, required valid=0 stop=1", flitOutValid, wordInStop);
      end
    end
    srst = 1'b0;
    tests_run++;
    if (wordInStop !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_init_cycle: got wordInStop=%b, required 1", wordInStop);
    end
    cycle();
    tests_run++;
    if (wordInStop !== 1'b0 || flitOutValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got stop=%b valid=%b, required stop=0 valid=0", wordInStop, flitOutValid);
    end
  endtask

  task automatic test_single();
    send(64'h4444_3333_2222_1111, 2'd3, 1'b1);
    tests_run++;
    if (flitOutValid !== 1'b1 || flitOutData !== 16'h1111) begin
      tests_failed++;
      $display("FAIL single_latency: got valid=%b data=%h, required valid=1 data=1111", flitOutValid, flitOutData);
    end
    drain("single");
  endtask

  task automatic test_back_to_back();
    gap_cnt = 0;
    send(64'hA004_A003_A002_A001, 2'd3, 1'b0);
    send(64'hB004_B003_B002_B001, 2'd3, 1'b1);
    drain("back_to_back");
    tests_run++;
    if (gap_cnt != 0) begin
      tests_failed++;
      $display("FAIL back_to_back_gaps: got %0d bubble cycles, required 0", gap_cnt);
    end
  endtask

  task automatic test_partial();
    send(64'h0000_0000_BBBB_AAAA, 2'd1, 1'b1);
    drain("partial");
    for (int i = 0; i < 3; i++) cycle();
    tests_run++;
    if (flitOutValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL partial_extra: got flitOutValid=%b, required 0", flitOutValid);
    end
  endtask

  task automatic test_backpressure();
    send(64'h4444_3333_2222_1111, 2'd3, 1'b0);
    cycle();
    flitOutStop = 1'b1;
    send(64'h8888_7777_6666_5555, 2'd3, 1'b1);
    tests_run++;
    if (wordInStop !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_stop: got wordInStop=%b, required 1", wordInStop);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (flitOutValid !== 1'b1 || flitOutData !== 16'h2222 || flitOutEof !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure_hold: got valid=%b data=%h eof=%b, required valid=1 data=2222 eof=0",
                 flitOutValid, flitOutData, flitOutEof);
      end
      cycle();
    end
    tests_run++;
    if (flitOutData !== 16'h2222) begin
      tests_failed++;
      $display("FAIL backpressure_hold_last: got data=%h, required 2222", flitOutData);
    end
    flitOutStop = 1'b0;
    drain("backpressure");
  endtask

  task automatic test_reset_mid_frame();
    send(64'h1D04_1D03_1D02_1D01, 2'd3, 1'b1);
    send(64'h2E04_2E03_2E02_2E01, 2'd3, 1'b1);
    cycle();
    tests_run++;
    if (wordInStop !== 1'b1 || flitOutData !== 16'h1D03) begin
      tests_failed++;
      $display("FAIL midreset_setup: got stop=%b data=%h, required stop=1 data=1d03", wordInStop, flitOutData);
    end
    srst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (flitOutValid !== 1'b0 || wordInStop !== 1'b1) begin
        tests_failed++;
        $display("FAIL midreset_hold: got valid=%b stop=%b, required valid=0 stop=1", flitOutValid, wordInStop);
      end
    end
    srst = 1'b0;
    cycle();
    send(64'h3F04_3F03_3F02_3F01, 2'd3, 1'b1);
    tests_run++;
    if (flitOutData !== 16'h3F01) begin
      tests_failed++;
      $display("FAIL midreset_first: got data=%h, required 3f01", flitOutData);
    end
    drain("midreset");
  endtask

  initial begin
    srst        = 1'b1;
    wordInValid = 1'b0;
    wordInData  = '0;
    wordInLen   = '0;
    wordInEof   = 1'b0;
    flitOutStop = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_partial();
    test_backpressure();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

endmodule

// File: doc/smi_self_link_flit_serializer.md
Name: smi_self_link_flit_serializer

Overview:
- SELF-link transmitter that splits wide frame words into a sequence of narrow flits, least-significant flit first.
- Each flit carries an end-of-frame marker.
- Sits between wide datapath producers and narrow SMI links; the deserializer at the far end of the link reassembles the words.
- Uses a double-register structure (staging plus shift register) so full flit throughput is sustained with no combinatorial path from flitOutStop to wordInStop.

Parameters:
- FlitWidth, 16, width of one output flit in bits.
- FlitsPerWord, 4, flits per input word; must be a power of two and at least 2.
- LenWidth, 2, equals log2(FlitsPerWord); width of the length field.

Ports:
- clk  input  1  clock.
- srst  input  1  reset: synchronous, active-high.
- wordInValid  input  1  upstream SELF valid.
- wordInData  input  FlitWidth*FlitsPerWord  frame word; flit 0 is bits [FlitWidth-1:0].
- wordInLen  input  LenWidth  number of valid flits minus 1 (0 = 1 flit, FlitsPerWord-1 = full word).
- wordInEof  input  1  word is the last word of the frame.
- wordInStop  output  1  upstream SELF stop; registered.
- flitOutValid  output  1  downstream SELF valid; registered.
- flitOutData  output  FlitWidth  current flit; registered.
- flitOutEof  output  1  current flit is the last flit of the frame; registered.
- flitOutStop  input  1  downstream SELF stop.

Behaviour:
- State:
  - Staging register ST holds data, len, eof and stFull.
  - Shift register SR holds data, eof and remaining count srCnt (0..FlitsPerWord).
- Outputs:
  - flitOutData = SR low flit.
  - flitOutValid = (srCnt != 0).
  - flitOutEof = SR.eof && (srCnt == 1).
  - wordInStop = stFull, or the init flag (see reset).
- Reset:
  - While srst is high: srCnt=0, stFull=0, init=1, so flitOutValid=0 and wordInStop=1.
  - The first cycle after release has init=1, so wordInStop=1 for exactly one more cycle; init then clears.
  - Data registers are not reset.
- Pop: occurs when flitOutValid && !flitOutStop. SR shifts right by FlitWidth and srCnt decrements.
- SR reload: happens when SR is empty, or when SR is popping its last flit (srCnt==1).
  - If stFull: SR loads from ST (srCnt = len+1, eof copied) and stFull clears.
  - Else, if an input is accepted this cycle: the input word loads directly into SR (bypass), giving 1-cycle latency from acceptance to first flit.
  - Otherwise SR becomes or stays empty.
- Accept: occurs when wordInValid && !wordInStop.
  - If the SR reload path takes the word (bypass), ST is untouched.
  - Otherwise the word loads into ST and stFull sets.
- Simultaneous events:
  - ST→SR transfer and accept never coincide, because wordInStop=1 whenever stFull=1.
  - A word accepted in the cycle ST empties is captured the next cycle.
- Throughput:
  - Back-to-back full words produce continuous flits with no bubble.
  - A 1-flit word every cycle sustains 1 flit/cycle once ST is in use.
- Backpressure: while flitOutStop=1, flitOutData, flitOutEof and flitOutValid are held stable. Upstream is stopped once ST fills.
- Frame rules:
  - flitOutEof asserts only on the final flit (index len) of a word with eof=1.
  - Flits beyond len are never emitted.
- Reset mid-frame: SR and ST contents are discarded with no partial flush; outputs go to their reset values the next cycle.
- Invariant: a word is never lost or duplicated, and flit order is preserved.

Decomposition:
- Shared smi package holds:
  - the default flit width constant (16);
  - the FlitsPerWord default;
  - a function deriving LenWidth from FlitsPerWord;
  - SELF handshake macros used by both serializer and deserializer.
- No sub-module; ST and SR are coded inline. Total RTL is roughly 150–200 lines.

Test Plan:
- Reset: hold srst for 3 cycles → flitOutValid=0 and wordInStop=1 throughout, wordInStop=1 for one further cycle, then wordInStop=0.
- Single word 0x4444_3333_2222_1111, len=3, eof=1, flitOutStop=0 → flits 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles, starting 1 cycle after acceptance; flitOutEof=1 only with 0x4444.
- Two back-to-back full words, eof=0 then eof=1, flitOutStop=0 → 8 consecutive valid flits with no gap; eof only on the 8th.
- Partial word 0x0000_0000_BBBB_AAAA, len=1, eof=1 → exactly 2 flits, 0xAAAA then 0xBBBB (eof=1); flitOutValid=0 afterwards.
- Backpressure: hold flitOutStop=1 for 5 cycles while on flit 1 of a word, with the next word offered → flitOutData stays 0x2222, wordInStop rises once the next word is staged, and all 8 flits are delivered in order after release.
- Reset mid-frame: assert srst after 2 flits of a 4-flit word, with ST full → next cycle flitOutValid=0; after the reset sequence a new word serializes correctly with no stale flits.
